// File: rtl/sa_strictsync_req_sched.sv
// Round-robin scheduler that serializes per-requester pending events onto one
// 4-phase req/ack crossing, with completion pulses, overflow and timeout flags.
module sa_strictsync_req_sched #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int CNT_W     = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic            CLK,
    input  logic            CLRN,
    input  logic            ENABLE,
    input  logic [NREQ-1:0] REQ_PULSE,
    input  logic            XFER_ACK,
    input  logic            ERR_CLR,
    output logic            XFER_REQ,
    output logic [IDW-1:0]  XFER_ID,
    output logic            BUSY,
    output logic [NREQ-1:0] PEND,
    output logic [NREQ-1:0] DONE,
    output logic [NREQ-1:0] OVF,
    output logic            TIMEOUT_ERR
);

    localparam int TW = $clog2(TO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]    TO_LAST = TW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ_HI, ACK_LO, ABORT} state_t;

    state_t                     state_q, state_d;
    logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]             last_grant_q, last_grant_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       xfer_req_q, xfer_req_d;
    logic [IDW-1:0]             xfer_id_q, xfer_id_d;
    logic [NREQ-1:0]            done_q, done_d;
    logic [NREQ-1:0]            ovf_q, ovf_d;
    logic                       to_err_q, to_err_d;

    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ovf_set;
    logic            to_set;
    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) pend[i] = (cnt_q[i] != '0);
    end

    // Scan starts one past the last grant so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!found && pend[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        xfer_req_d   = xfer_req_q;
        xfer_id_d    = xfer_id_q;
        last_grant_d = last_grant_q;
        done_d       = '0;
        grant        = '0;
        to_set       = 1'b0;
        ovf_set      = '0;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                // A stale ack still high from the last handshake blocks grants.
                if (ENABLE && found && !XFER_ACK) begin
                    state_d       = REQ_HI;
                    xfer_req_d    = 1'b1;
                    xfer_id_d     = winner;
                    last_grant_d  = winner;
                    grant[winner] = 1'b1;
                    timer_d       = '0;
                end
            end
            REQ_HI: begin
                if (XFER_ACK) begin
                    state_d    = ACK_LO;
                    xfer_req_d = 1'b0;
                    timer_d    = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d    = ABORT;
                    xfer_req_d = 1'b0;
                    to_set     = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ACK_LO: begin
                if (!XFER_ACK) begin
                    state_d           = IDLE;
                    done_d[xfer_id_q] = 1'b1;
                end else if (timer_q == TO_LAST) begin
                    state_d = ABORT;
                    to_set  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                xfer_req_d = 1'b0;
                if (!XFER_ACK) state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NREQ; i++) begin
            if (REQ_PULSE[i] && !grant[i]) begin
                if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
                else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end else if (!REQ_PULSE[i] && grant[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        // Set events win over a simultaneous clear.
        ovf_d    = (ERR_CLR ? '0 : ovf_q) | ovf_set;
        to_err_d = (to_err_q && !ERR_CLR) || to_set;
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            timer_q      <= '0;
            xfer_req_q   <= 1'b0;
            xfer_id_q    <= '0;
            done_q       <= '0;
            ovf_q        <= '0;
            to_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            xfer_req_q   <= xfer_req_d;
            xfer_id_q    <= xfer_id_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            to_err_q     <= to_err_d;
        end
    end

    assign XFER_REQ    = xfer_req_q;
    assign XFER_ID     = xfer_id_q;
    assign BUSY        = (state_q != IDLE);
    assign PEND        = pend;
    assign DONE        = done_q;
    assign OVF         = ovf_q;
    assign TIMEOUT_ERR = to_err_q;

endmodule

// File: doc/sa_strictsync_req_sched.md
Name: sa_strictsync_req_sched

Overview:
Source-domain scheduler that serializes event requests from NREQ local requesters onto a single 4-phase req/ack crossing.
- XFER_REQ drives the SRC_D_NEXT input of a strict-sync crossing cell.
- XFER_ACK is the return acknowledge, already synchronized into CLK by a 3-flop sync cell.
- Per-requester pending counters are served round-robin.
- Provides completion pulses, overflow flags and a handshake timeout.

Parameters:
NREQ, 4, number of requesters
IDW, 2, width of XFER_ID; must equal clog2(NREQ), minimum 1
CNT_W, 3, per-requester pending counter width; saturates at 2^CNT_W-1
TO_CYCLES, 64, cycles allowed in a handshake phase before timeout; minimum 2

Ports:
CLK  in  1  single clock
CLRN  in  1  asynchronous active-low reset
ENABLE  in  1  permits new grants
REQ_PULSE  in  NREQ  one-cycle event per requester; multiple bits may be set at once
XFER_ACK  in  1  synchronized acknowledge from destination
ERR_CLR  in  1  clears the sticky OVF and TIMEOUT_ERR flags
XFER_REQ  out  1  registered request level to the crossing cell
XFER_ID  out  IDW  registered id of the granted requester; stable while XFER_REQ=1
BUSY  out  1  high whenever the FSM is not in IDLE
PEND  out  NREQ  PEND[i] = (cnt[i] != 0)
DONE  out  NREQ  one-cycle completion pulse, registered
OVF  out  NREQ  sticky: a request was dropped at saturation
TIMEOUT_ERR  out  1  sticky handshake timeout

Behaviour:
- Reset (CLRN low, asynchronous):
  - All outputs are 0.
  - FSM goes to IDLE; all counters and the timer are 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Reset mid-handshake drops XFER_REQ immediately and loses all pending counts.
- Pending counters, evaluated per requester every cycle:
  - inc = REQ_PULSE[i]; dec = grant of i this cycle.
  - inc and dec together: count unchanged.
  - inc only, count below max: count+1.
  - inc only, count at max: count unchanged and OVF[i] set.
  - dec only: count-1.
- FSM states: IDLE, REQ_HI, ACK_LO, ABORT.
  - IDLE -> REQ_HI when ENABLE=1, any cnt!=0 (registered value) and XFER_ACK=0.
    - Winner is the first pending index scanning from last_grant+1 with wrap.
    - Same edge: XFER_REQ<=1, XFER_ID<=winner, last_grant<=winner, cnt[winner] decrements.
    - If XFER_ACK=1 while in IDLE (stale ack), no grant is made.
  - REQ_HI: XFER_ACK=1 -> XFER_REQ<=0, go to ACK_LO.
  - ACK_LO: XFER_ACK=0 -> DONE[XFER_ID]<=1 for one cycle, go to IDLE.
  - ABORT: XFER_REQ=0; when XFER_ACK=0, go to IDLE with no DONE. The consumed count is not restored.
- Latency:
  - REQ_PULSE at edge t gives the count at t+1.
  - XFER_REQ rises at t+2 if the FSM is idle.
  - Every transfer spends at least one cycle in IDLE before the next grant.
- Timer:
  - Cleared on entry to REQ_HI and to ACK_LO; increments each cycle in those states.
  - When the timer reaches TO_CYCLES-1 without the awaited ack edge, TIMEOUT_ERR<=1 and XFER_REQ<=0.
    - From REQ_HI: go to ABORT.
    - From ACK_LO: go to ABORT.
  - An ack edge in the same cycle as the timer limit has priority; no timeout is flagged.
- ENABLE=0 blocks only new grants; a transfer already in progress completes normally.
- ERR_CLR clears OVF and TIMEOUT_ERR. A set event in the same cycle as ERR_CLR wins, so the flag stays 1.
- XFER_REQ and XFER_ID come directly from flops, with no combinational path from inputs, as required by the crossing cell.

Test Plan:
1. Single request:
   - Stimulus: after reset, REQ_PULSE=0001 at cycle 0; ack returns 3 cycles after XFER_REQ rises and drops 3 cycles after XFER_REQ falls.
   - Required: XFER_REQ rises at cycle 2 with XFER_ID=0, DONE=0001 for exactly one cycle, PEND=0 afterwards, BUSY low after DONE.
2. Round-robin:
   - Stimulus: REQ_PULSE=1111 in one cycle, auto-ack responder.
   - Required: grant order of ids is 0,1,2,3; four DONE pulses in that order; no OVF.
3. Saturation:
   - Stimulus: 8 pulses on requester 2 while ENABLE=0, then ENABLE=1.
   - Required: after the 8th pulse OVF=0100 and cnt stays at 7; exactly 7 transfers with id 2 follow; ERR_CLR then gives OVF=0.
4. Simultaneous increment and grant:
   - Stimulus: requester 1 at count 1 pulses in the same cycle it is granted.
   - Required: count stays 1 and a second transfer with id 1 follows.
5. Timeout:
   - Stimulus: responder never acks.
   - Required: TIMEOUT_ERR=1 and XFER_REQ=0 exactly TO_CYCLES cycles after XFER_REQ rose; no DONE; FSM returns to IDLE and the next pending requester is served.
6. Reset mid-handshake:
   - Stimulus: CLRN low during REQ_HI.
   - Required: XFER_REQ and all outputs go to 0 asynchronously; after release, no transfer occurs without a new REQ_PULSE.
